// File: rtl/uart_host_rx.sv
// Host-side UART receiver: 16x oversampled deserializer with start/parity/stop
// checking and a one-entry valid/ready output buffer with sticky overrun.
module uart_host_rx #(
  parameter int CLK_FREQ_HZ = 20000000,
  parameter int BAUDRATE    = 9600,
  parameter int N_DATA_BITS = 8,
  parameter int PARITY_EN   = 0,
  parameter int PARITY_ODD  = 0,
  parameter int STOP_BITS   = 1,
  parameter int LSB_FIRST   = 1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       parity_err_o,
  output logic       frame_err_o,
  output logic       break_o,
  output logic       overrun_o,
  input  logic       ovr_clr_i,
  output logic       busy_o
);

  localparam int DIV = CLK_FREQ_HZ / (16 * BAUDRATE);
  localparam int CW  = $clog2(DIV + 1);
  localparam int SHR = 8 - N_DATA_BITS;
  localparam logic [7:0] DMASK = 8'((1 << N_DATA_BITS) - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK_WAIT} state_t;

  state_t        state, state_nxt;
  logic          rx_sync_p0, rx_s, rx_prev;
  logic [CW-1:0] div_cnt;
  logic          tick;
  logic [3:0]    ph;
  logic [2:0]    bcnt;
  logic          scnt;
  logic [7:0]    sh;
  logic          perr_pend, ferr_pend, brk_pend, par_zero_pend;
  logic          start_edge, start_smp, mid, last_stop;
  logic          brk_now, ferr_now, load_try, load_ok;
  logic [7:0]    data_fin;

  // The shift register fills from the top when LSB first, so realign to bit 0.
  function automatic logic [7:0] align_data(input logic [7:0] s);
    if (LSB_FIRST != 0) return s >> SHR;
    else                return s & DMASK;
  endfunction

  assign tick       = (div_cnt == CW'(DIV - 1));
  assign start_edge = (state == IDLE) && rx_prev && !rx_s;
  assign start_smp  = (state == START) && tick && (ph == 4'd7);
  assign mid        = tick && (ph == 4'd15);
  assign last_stop  = (scnt == 1'(STOP_BITS - 1));
  assign data_fin   = align_data(sh);
  assign brk_now    = !scnt ? ((data_fin == 8'd0) && par_zero_pend && !rx_s) : brk_pend;
  assign ferr_now   = ferr_pend || !rx_s;
  assign load_try   = (state == STOP) && mid && last_stop;
  assign load_ok    = load_try && (!valid_o || ready_i);
  assign busy_o     = (state != IDLE);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (start_edge) state_nxt = START;
      START:    if (start_smp) state_nxt = rx_s ? IDLE : DATA;
      DATA:     if (mid && (bcnt == 3'(N_DATA_BITS - 1)))
                  state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY:   if (mid) state_nxt = STOP;
      STOP:     if (mid && last_stop) state_nxt = brk_now ? BRK_WAIT : IDLE;
      BRK_WAIT: if (rx_s) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Stage: input synchronizer and bit-timing counters
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      rx_sync_p0 <= 1'b1;
      rx_s       <= 1'b1;
      rx_prev    <= 1'b1;
      div_cnt    <= '0;
      ph         <= 4'd0;
      bcnt       <= 3'd0;
      scnt       <= 1'b0;
    end else begin
      state      <= state_nxt;
      rx_sync_p0 <= rx_i;
      rx_s       <= rx_sync_p0;
      rx_prev    <= rx_s;
      if (start_edge || tick) div_cnt <= '0;
      else                    div_cnt <= div_cnt + CW'(1);
      if (start_edge || start_smp) ph <= 4'd0;
      else if (tick)               ph <= ph + 4'd1;
      if (start_edge)                  bcnt <= 3'd0;
      else if ((state == DATA) && mid) bcnt <= bcnt + 3'd1;
      if (start_edge)                  scnt <= 1'b0;
      else if ((state == STOP) && mid) scnt <= scnt + 1'b1;
    end
  end

  // Stage: frame assembly and pending error flags
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sh            <= 8'd0;
      perr_pend     <= 1'b0;
      ferr_pend     <= 1'b0;
      brk_pend      <= 1'b0;
      par_zero_pend <= 1'b1;
    end else if (start_edge) begin
      sh            <= 8'd0;
      perr_pend     <= 1'b0;
      ferr_pend     <= 1'b0;
      brk_pend      <= 1'b0;
      par_zero_pend <= 1'b1;
    end else if (mid) begin
      if (state == DATA) begin
        if (LSB_FIRST != 0) sh <= {rx_s, sh[7:1]};
        else                sh <= {sh[6:0], rx_s};
      end
      if (state == PARITY) begin
        perr_pend     <= (rx_s != ((^data_fin) ^ (PARITY_ODD != 0)));
        par_zero_pend <= !rx_s;
      end
      if (state == STOP) begin
        if (!rx_s) ferr_pend <= 1'b1;
        if (!scnt) brk_pend  <= brk_now;
      end
    end
  end

  // Stage: output buffer and overrun
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_o      <= 1'b0;
      data_o       <= 8'd0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      break_o      <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      if (load_ok) begin
        valid_o      <= 1'b1;
        data_o       <= data_fin;
        parity_err_o <= perr_pend;
        frame_err_o  <= ferr_now;
        break_o      <= brk_now;
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
      if (load_try && !load_ok) overrun_o <= 1'b1;
      else if (ovr_clr_i)       overrun_o <= 1'b0;
    end
  end

endmodule

// File: doc/uart_host_rx.md
Name: uart_host_rx

Overview:
Host-side serial receiver that deserializes the UART core's stx_pad_o line back into bytes, the reverse of the bench's host-to-device transmit path. It oversamples the line at 16x the baud rate, checks start, parity and stop framing, and hands each frame to a consumer through a one-entry valid/ready buffer. It is synthesizable and sits beside the UART core in bench and FPGA loopback builds.

Parameters:
CLK_FREQ_HZ, 20000000, system clock frequency in Hz
BAUDRATE, 9600, bits per second
N_DATA_BITS, 8, data bits per frame, legal range 5..8
PARITY_EN, 0, 1 = a parity bit follows the data bits
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (used only when PARITY_EN=1)
STOP_BITS, 1, 1 or 2
LSB_FIRST, 1, 1 = data LSB first, 0 = MSB first

Ports:
clk  input  1  system clock; single clock domain
rstn  input  1  asynchronous active-low reset
rx_i  input  1  serial line, asynchronous to clk, idles high
data_o  output  8  received data; bits above N_DATA_BITS are 0
valid_o  output  1  data_o, parity_err_o, frame_err_o and break_o hold a frame
ready_i  input  1  consumer accepts the frame when valid_o && ready_i
parity_err_o  output  1  parity mismatch on the buffered frame
frame_err_o  output  1  a stop bit sampled 0 on the buffered frame
break_o  output  1  buffered frame was a break condition
overrun_o  output  1  sticky: a frame was dropped because the buffer was full
ovr_clr_i  input  1  clears overrun_o
busy_o  output  1  FSM is not in IDLE

Behaviour:
- Reset: all outputs 0; synchronizer flops reset to 1; FSM goes to IDLE; tick counter and bit counters reset to 0.
- Synchronizer: rx_i passes through 2 flops to give rx_s; all logic uses rx_s.
- Tick generator:
  - DIV = CLK_FREQ_HZ/(16*BAUDRATE), integer truncation; 130 at the defaults.
  - One-cycle tick every DIV clocks; the counter is cleared when a start edge is detected.
- FSM states: IDLE, START, DATA, PARITY, STOP, BRK_WAIT.
- IDLE: a 1->0 transition on rx_s goes to START with the tick phase counter at 0.
- START: on tick phase 7 (mid-bit), sample rx_s.
  - rx_s = 1: false start, return to IDLE; nothing is buffered.
  - rx_s = 0: go to DATA.
- DATA: sample every 16 ticks, N_DATA_BITS times.
  - Shift toward the LSB when LSB_FIRST=1, otherwise toward the MSB.
  - Then go to PARITY if PARITY_EN=1, else STOP.
- PARITY: sample the bit.
  - Expected value = ^data XOR PARITY_ODD.
  - A mismatch sets the pending parity error.
- STOP: sample STOP_BITS stop bits, 16 ticks apart.
  - Any stop bit sampled 0 sets the pending frame error.
  - On the last stop sample, attempt a buffer load.
- Break: data all 0, parity bit (if enabled) 0, and first stop bit 0.
  - Sets the pending break flag.
  - After the load attempt the FSM goes to BRK_WAIT and stays there until rx_s = 1, then goes to IDLE.
- No break: IDLE is re-entered on the cycle after the last stop sample.
- Buffer load, registered: valid_o and the frame fields update 1 clk after the last stop sample tick.
  - The load succeeds if valid_o = 0, or if ready_i = 1 in the load cycle (accept and load in the same cycle, no overrun).
  - Otherwise the new frame is dropped, the old frame is kept unchanged, and overrun_o is set.
- Handshake:
  - valid_o stays high and data/flags stay stable until ready_i is sampled high.
  - valid_o drops the cycle after acceptance unless a new load happens in that same cycle.
- overrun_o: cleared by ovr_clr_i. If a set and ovr_clr_i happen in the same cycle, the set wins.
- Error flags describe the buffered frame only; they are replaced on each load.
- Errors never abort reception mid-frame. FSM timing depends only on rx_s edges in IDLE.
- busy_o = (state != IDLE). It is combinational from the state register.

Test Plan:
- Defaults, host sends 0xA5 (start, bits 1,0,1,0,0,1,0,1, stop), ready_i=1 -> valid_o pulses once, data_o=0xA5, parity_err_o=0, frame_err_o=0, break_o=0; the pulse lands about 9.5*2080 clk after the start edge.
- N_DATA_BITS=7, PARITY_EN=1 even: send 0x41 with parity 0 -> data_o=0x41, parity_err_o=0. Send 0x41 with parity 1 -> parity_err_o=1, data still delivered.
- Glitch: rx_i low for 5*130 clk then high -> no valid_o, FSM returns to IDLE, busy_o back to 0. A following 0x3C frame is received correctly.
- Stop bit forced 0 on 0x55 -> frame_err_o=1, data_o=0x55. Line held low for 20 bit times -> break_o=1, data_o=0x00, FSM holds in BRK_WAIT until the line returns high, then IDLE.
- ready_i=0, send 0x11 then 0x22 -> data_o stays 0x11, overrun_o=1. Pulse ready_i -> valid_o drops. Assert ovr_clr_i -> overrun_o=0. Send 0x33 with ready_i rising exactly in the load cycle -> data_o=0x33, no overrun.
- Assert rstn low mid-DATA of 0x77 -> all outputs 0 asynchronously. Release with the line idle -> no spurious frame; the next 0x77 is received cleanly.
